// File: rtl/cc_randomselect_pkg.sv
// cc_randomselect_pkg: shared state encoding, LFSR taps, select codes and pattern pick
package cc_randomselect_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GAP  = 2'd1,
        EMIT = 2'd2
    } state_t;

    // Feedback taps for x^8 + x^6 + x^5 + x^4 + 1 (bit indices of the 8-bit register)
    localparam int TAP_A = 7;
    localparam int TAP_B = 5;
    localparam int TAP_C = 4;
    localparam int TAP_D = 3;

    localparam logic [1:0] NADA = 2'd0;
    localparam logic [1:0] R1   = 2'd1;
    localparam logic [1:0] R2   = 2'd2;
    localparam logic [1:0] R3   = 2'd3;

    // Pattern choice from the LFSR: first nonzero of bits[4:3], bits[6:5], else pattern 1
    function automatic logic [1:0] pick(input logic [7:0] v);
        return (v[4:3] != NADA) ? v[4:3] : (v[6:5] != NADA) ? v[6:5] : R1;
    endfunction

endpackage

// File: rtl/cc_lfsr8.sv
// cc_lfsr8: free-running 8-bit Fibonacci LFSR with a lock-up guard back to the seed
module cc_lfsr8
    import cc_randomselect_pkg::*;
#(
    parameter int                   LFSRWIDTH = 8,
    parameter logic [LFSRWIDTH-1:0] SEED      = 8'hA5
) (
    input  logic                 CC_LFSR8_CLOCK_50,
    input  logic                 CC_LFSR8_RESET_InLow,
    output logic [LFSRWIDTH-1:0] CC_LFSR8_lfsr_OutBUS
);

    logic [LFSRWIDTH-1:0] r_lfsr;
    logic                 w_fb;

    assign w_fb = r_lfsr[TAP_A] ^ r_lfsr[TAP_B] ^ r_lfsr[TAP_C] ^ r_lfsr[TAP_D];
    assign CC_LFSR8_lfsr_OutBUS = r_lfsr;

    // Shift every clock; an all-zero register would stick, so reload the seed instead
    always_ff @(posedge CC_LFSR8_CLOCK_50 or negedge CC_LFSR8_RESET_InLow) begin
        if (!CC_LFSR8_RESET_InLow)
            r_lfsr <= SEED;
        else
            r_lfsr <= (r_lfsr == '0) ? SEED : {r_lfsr[LFSRWIDTH-2:0], w_fb};
    end

endmodule

// File: rtl/cc_random_select_gen.sv
// cc_random_select_gen: gap/emit sequencer driving the random-obstacle pattern mux select
module cc_random_select_gen
    import cc_randomselect_pkg::*;
#(
    parameter int                   SELECTWIDTH = 2,
    parameter int                   LFSRWIDTH   = 8,
    parameter logic [LFSRWIDTH-1:0] SEED        = 8'hA5,
    parameter int                   MINGAP      = 2,
    parameter int                   HOLD        = 1
) (
    input  logic                   CC_RANDOMSELECT_CLOCK_50,
    input  logic                   CC_RANDOMSELECT_RESET_InLow,
    input  logic                   CC_RANDOMSELECT_enable_In,
    input  logic                   CC_RANDOMSELECT_tick_In,
    output logic [SELECTWIDTH-1:0] CC_RANDOMSELECT_select_OutBUS,
    output logic                   CC_RANDOMSELECT_new_Out,
    output logic                   CC_RANDOMSELECT_busy_Out,
    output logic [LFSRWIDTH-1:0]   CC_RANDOMSELECT_lfsr_OutBUS
);

    state_t                 r_state;
    logic [SELECTWIDTH-1:0] r_select;
    logic                   r_new;
    logic [3:0]             r_gap_cnt;
    logic [3:0]             r_hold_cnt;
    logic [LFSRWIDTH-1:0]   w_lfsr;
    logic [3:0]             w_gap_load;

    cc_lfsr8 #(
        .LFSRWIDTH (LFSRWIDTH),
        .SEED      (SEED)
    ) u_lfsr (
        .CC_LFSR8_CLOCK_50    (CC_RANDOMSELECT_CLOCK_50),
        .CC_LFSR8_RESET_InLow (CC_RANDOMSELECT_RESET_InLow),
        .CC_LFSR8_lfsr_OutBUS (w_lfsr)
    );

    assign w_gap_load = 4'(MINGAP) + {1'b0, w_lfsr[2:0]};

    assign CC_RANDOMSELECT_select_OutBUS = r_select;
    assign CC_RANDOMSELECT_new_Out       = r_new;
    assign CC_RANDOMSELECT_busy_Out      = (r_state != IDLE);
    assign CC_RANDOMSELECT_lfsr_OutBUS   = w_lfsr;

    // Sequencer: disable wins over tick; gap and emit windows count down one tick at a time
    always_ff @(posedge CC_RANDOMSELECT_CLOCK_50 or negedge CC_RANDOMSELECT_RESET_InLow) begin
        if (!CC_RANDOMSELECT_RESET_InLow) begin
            r_state    <= IDLE;
            r_select   <= NADA;
            r_new      <= 1'b0;
            r_gap_cnt  <= '0;
            r_hold_cnt <= '0;
        end else begin
            r_new <= 1'b0;
            if (r_state == IDLE) begin
                if (CC_RANDOMSELECT_enable_In) begin
                    r_state   <= GAP;
                    r_gap_cnt <= w_gap_load;
                end
            end else if (!CC_RANDOMSELECT_enable_In) begin
                r_state    <= IDLE;
                r_select   <= NADA;
                r_gap_cnt  <= '0;
                r_hold_cnt <= '0;
            end else if (CC_RANDOMSELECT_tick_In) begin
                if (r_state == GAP) begin
                    if (r_gap_cnt == 4'd1) begin
                        r_state    <= EMIT;
                        r_select   <= pick(w_lfsr);
                        r_hold_cnt <= 4'(HOLD);
                        r_new      <= 1'b1;
                    end else begin
                        r_gap_cnt <= r_gap_cnt - 4'd1;
                    end
                end else begin
                    if (r_hold_cnt == 4'd1) begin
                        r_state   <= GAP;
                        r_select  <= NADA;
                        r_gap_cnt <= w_gap_load;
                    end else begin
                        r_hold_cnt <= r_hold_cnt - 4'd1;
                    end
                end
            end
        end
    end

endmodule
